// File: rtl/vga_page_sequencer_if.sv
// Request/response bundle between the page requester and vga_page_sequencer,
// plus the mode/next_mode/shift lines that feed the VGA top level.
interface vga_page_sequencer_if;
    logic       frame_tick;
    logic       req_valid;
    logic [7:0] req_mode;
    logic       req_ready;
    logic       abort;
    logic [7:0] mode;
    logic [7:0] next_mode;
    logic [1:0] shift;
    logic       busy;
    logic       done;

    modport master (
        output frame_tick, req_valid, req_mode, abort,
        input  req_ready, mode, next_mode, shift, busy, done
    );

    modport slave (
        input  frame_tick, req_valid, req_mode, abort,
        output req_ready, mode, next_mode, shift, busy, done
    );
endinterface

// File: rtl/vga_page_sequencer.sv
// Frame-aligned page-transition controller: steps shift 1..3 over whole frames,
// then commits the requested mode so the renderer never sees a mid-frame change.
module vga_page_sequencer #(
    parameter int         FRAMES_PER_STEP = 4,
    parameter logic [7:0] RESET_MODE      = 8'h00
) (
    input logic                 sys_clk,
    input logic                 sys_rst,
    vga_page_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;

    localparam logic [7:0] LAST_CNT = 8'(FRAMES_PER_STEP - 1);

    logic [1:0] state;
    logic [7:0] frame_cnt;

    assign bus.req_ready = (state == ST_IDLE);

    // NOTE: every register below is updated with <= so all of them see the
    // pre-edge values of each other; blocking '=' here would create ordering races.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            frame_cnt     <= 8'd0;
            bus.mode      <= RESET_MODE;
            bus.next_mode <= RESET_MODE;
            bus.shift     <= 2'd0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;

            if (state != ST_IDLE && bus.abort) begin
                // Abort beats a coincident committing tick: mode stays put.
                state         <= ST_IDLE;
                frame_cnt     <= 8'd0;
                bus.next_mode <= bus.mode;
                bus.shift     <= 2'd0;
                bus.busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.req_valid) begin
                            if (bus.req_mode == bus.mode) begin
                                bus.done <= 1'b1;
                            end else begin
                                bus.next_mode <= bus.req_mode;
                                bus.busy      <= 1'b1;
                                state         <= ST_ALIGN;
                            end
                        end
                    end

                    ST_ALIGN: begin
                        if (bus.frame_tick) begin
                            bus.shift <= 2'd1;
                            frame_cnt <= 8'd0;
                            state     <= ST_STEP;
                        end
                    end

                    ST_STEP: begin
                        if (bus.frame_tick) begin
                            if (frame_cnt == LAST_CNT) begin
                                frame_cnt <= 8'd0;
                                if (bus.shift == 2'd3) begin
                                    bus.mode  <= bus.next_mode;
                                    bus.shift <= 2'd0;
                                    bus.done  <= 1'b1;
                                    bus.busy  <= 1'b0;
                                    state     <= ST_IDLE;
                                end else begin
                                    bus.shift <= bus.shift + 2'd1;
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                        end
                    end

                    default: begin
                        state     <= ST_IDLE;
                        frame_cnt <= 8'd0;
                        bus.shift <= 2'd0;
                        bus.busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
